// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU command scheduler.
// Opcodes, flag bit positions, FSM state encoding and the queued command layout.
package fpu_pkg;

  localparam int unsigned OpW      = 3;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned NumFlags = 5;

  localparam logic [OpW-1:0] OP_ADD  = 3'd0;
  localparam logic [OpW-1:0] OP_MUL  = 3'd1;
  localparam logic [OpW-1:0] OP_DIV  = 3'd2;
  localparam logic [OpW-1:0] OP_SQRT = 3'd3;
  localparam logic [OpW-1:0] OP_CMP  = 3'd4;

  // Bit positions within fpu_flags / sticky_flags: {inv, div_zero, ov, un, inexact}
  localparam int unsigned FLAG_NX  = 0;
  localparam int unsigned FLAG_UF  = 1;
  localparam int unsigned FLAG_OF  = 2;
  localparam int unsigned FLAG_DZ  = 3;
  localparam int unsigned FLAG_INV = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StExec   = 2'd2,
    StRetire = 2'd3
  } fpu_state_e;

  typedef struct packed {
    logic [OpW-1:0]      opcode;
    logic [RegAddrW-1:0] src1;
    logic [RegAddrW-1:0] src2;
    logic [RegAddrW-1:0] dst;
  } fpu_cmd_t;

  localparam int unsigned CmdW = $bits(fpu_cmd_t);

  function automatic logic op_is_legal(input logic [OpW-1:0] op);
    case (op)
      OP_ADD, OP_MUL, OP_DIV, OP_SQRT, OP_CMP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_sched_if.sv
// Command, FPU-control and status signals of the scheduler.
// The scheduler uses the slave view; whoever issues commands and models the FPU uses master.
interface fpu_sched_if;
  import fpu_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OpW-1:0]      cmd_opcode;
  logic [RegAddrW-1:0] cmd_src1;
  logic [RegAddrW-1:0] cmd_src2;
  logic [RegAddrW-1:0] cmd_dst;

  logic [OpW-1:0]      fpu_opcode;
  logic [RegAddrW-1:0] fpu_addr1;
  logic [RegAddrW-1:0] fpu_addr2;
  logic [RegAddrW-1:0] fpu_addr3;
  logic                fpu_ld;
  logic                fpu_enable;
  logic                fpu_done;
  logic [NumFlags-1:0] fpu_flags;

  logic                flags_clr;
  logic [NumFlags-1:0] sticky_flags;
  logic                busy;
  logic                retired;
  logic                timeout_err;
  logic                illegal_op;

  modport master (
    output cmd_valid, cmd_opcode, cmd_src1, cmd_src2, cmd_dst,
    output fpu_done, fpu_flags, flags_clr,
    input  cmd_ready, fpu_opcode, fpu_addr1, fpu_addr2, fpu_addr3, fpu_ld, fpu_enable,
    input  sticky_flags, busy, retired, timeout_err, illegal_op
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_src1, cmd_src2, cmd_dst,
    input  fpu_done, fpu_flags, flags_clr,
    output cmd_ready, fpu_opcode, fpu_addr1, fpu_addr2, fpu_addr3, fpu_ld, fpu_enable,
    output sticky_flags, busy, retired, timeout_err, illegal_op
  );

endinterface

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO; pushes while full and pops while empty are dropped.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fpu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned Width = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);

  logic [Width-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_sched.sv
// Queues FPU commands and sequences them IDLE -> LOAD -> EXEC -> RETIRE,
// with an EXEC timeout, illegal-opcode drop and sticky exception flags.
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst,
  fpu_sched_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

  fpu_state_e          state_q, state_d;
  fpu_cmd_t            cur_q, cur_d;
  fpu_cmd_t            push_cmd, head_cmd;
  logic [CntW-1:0]     wait_q, wait_d;
  logic [NumFlags-1:0] sticky_q, sticky_d;
  logic                timeout_q, timeout_d;
  logic                illegal_q, illegal_d;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic                drop_illegal;

  always_comb begin
    push_cmd        = '0;
    push_cmd.opcode = bus.cmd_opcode;
    push_cmd.src1   = bus.cmd_src1;
    push_cmd.src2   = bus.cmd_src2;
    push_cmd.dst    = bus.cmd_dst;
  end

  fpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .Width (CmdW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (bus.cmd_valid),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    illegal_d    = illegal_q;
    fifo_pop     = 1'b0;
    drop_illegal = 1'b0;
    // Clear applies before any merge so flags arriving in the same cycle survive.
    sticky_d     = bus.flags_clr ? '0 : sticky_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (op_is_legal(head_cmd.opcode)) begin
            cur_d   = head_cmd;
            state_d = StLoad;
          end else begin
            illegal_d    = 1'b1;
            drop_illegal = 1'b1;
          end
        end
      end
      StLoad: begin
        wait_d  = '0;
        state_d = StExec;
      end
      StExec: begin
        if (bus.fpu_done) begin
          sticky_d = sticky_d | bus.fpu_flags;
          state_d  = StRetire;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StRetire;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      StRetire: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      wait_q    <= '0;
      sticky_q  <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      wait_q    <= wait_d;
      sticky_q  <= sticky_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.cmd_ready    = !fifo_full;
  assign bus.fpu_opcode   = cur_q.opcode;
  assign bus.fpu_addr1    = cur_q.src1;
  assign bus.fpu_addr2    = cur_q.src2;
  assign bus.fpu_addr3    = cur_q.dst;
  assign bus.fpu_ld       = (state_q == StLoad);
  assign bus.fpu_enable   = (state_q == StLoad) || (state_q == StExec);
  assign bus.retired      = (state_q == StRetire) || drop_illegal;
  assign bus.busy         = (state_q != StIdle) || !fifo_empty;
  assign bus.sticky_flags = sticky_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.illegal_op   = illegal_q;

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched: directed scenarios plus a randomized run
// against a transaction-level model (command queue, flag OR-accumulation).
module tb_fpu_sched;
  import fpu_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fpu_sched_if bus ();

  fpu_sched #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_src1   = '0;
    bus.cmd_src2   = '0;
    bus.cmd_dst    = '0;
    bus.fpu_done   = 1'b0;
    bus.fpu_flags  = '0;
    bus.flags_clr  = 1'b0;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [4:0] s1, s2, d);
    bus.cmd_opcode = op;
    bus.cmd_src1   = s1;
    bus.cmd_src2   = s2;
    bus.cmd_dst    = d;
  endtask

  // Pushes one command into an idle scheduler and plays the FPU: done is raised on the
  // EXEC cycle numbered done_at (0-based), never if done_at < 0.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] s1, s2, d, input int done_at,
                         input logic [4:0] fl, input bit clr,
                         output int ld_cyc, output int exec_cyc, output bit ret);
    ld_cyc = 0; exec_cyc = 0; ret = 1'b0;
    set_cmd(op, s1, s2, d);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 60 && !ret; i++) begin
      bus.fpu_done  = 1'b0;
      bus.flags_clr = 1'b0;
      if (bus.retired) begin
        ret = 1'b1;
      end else begin
        if (bus.fpu_ld) ld_cyc++;
        else if (bus.fpu_enable) begin
          if (exec_cyc == done_at) begin
            bus.fpu_done = 1'b1; bus.fpu_flags = fl; bus.flags_clr = clr;
          end
          exec_cyc++;
        end
        step();
      end
    end
    bus.fpu_done  = 1'b0;
    bus.flags_clr = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.fpu_ld !== 1'b0 || bus.fpu_enable !== 1'b0 || bus.retired !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ld/en/ret=%b%b%b expected 000",
                         bus.fpu_ld, bus.fpu_enable, bus.retired); end
    checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs: busy/ready=%b%b expected 01", bus.busy, bus.cmd_ready); end
    checks++; if (bus.sticky_flags !== 5'b0 || bus.timeout_err !== 1'b0 || bus.illegal_op !== 1'b0)
    begin errors++; $display("FAIL reset_status: sticky=%b to=%b ill=%b expected 0",
                             bus.sticky_flags, bus.timeout_err, bus.illegal_op); end
    checks++; if ({bus.fpu_opcode, bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3} !== 18'h0) begin
      errors++; $display("FAIL reset_cur: op/addr=%h expected 0",
                         {bus.fpu_opcode, bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_add();
    set_cmd(OP_ADD, 5'd1, 5'd2, 5'd3);
    bus.cmd_valid = 1'b1;                      // cycle 0
    step(); bus.cmd_valid = 1'b0;              // cycle 1: pop
    checks++; if (bus.fpu_ld !== 1'b0 || bus.fpu_enable !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL add_c1: ld/en/busy=%b%b%b expected 001",
                         bus.fpu_ld, bus.fpu_enable, bus.busy); end
    step();                                    // cycle 2: LOAD
    checks++; if (bus.fpu_ld !== 1'b1 || bus.fpu_enable !== 1'b1) begin
      errors++; $display("FAIL add_load: ld/en=%b%b expected 11", bus.fpu_ld, bus.fpu_enable); end
    checks++; if ({bus.fpu_opcode, bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3} !==
                  {OP_ADD, 5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL add_addr_load: %0d/%0d/%0d expected 1/2/3",
                         bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3); end
    step();                                    // cycle 3: EXEC
    checks++; if (bus.fpu_ld !== 1'b0 || bus.fpu_enable !== 1'b1) begin
      errors++; $display("FAIL add_exec: ld/en=%b%b expected 01", bus.fpu_ld, bus.fpu_enable); end
    step(); step();                            // cycle 5
    bus.fpu_done = 1'b1; bus.fpu_flags = 5'b0;
    checks++; if (bus.retired !== 1'b0 || bus.fpu_enable !== 1'b1) begin
      errors++; $display("FAIL add_c5: ret/en=%b%b expected 01", bus.retired, bus.fpu_enable); end
    step(); bus.fpu_done = 1'b0;               // cycle 6: RETIRE
    checks++; if (bus.retired !== 1'b1 || bus.fpu_enable !== 1'b0 || bus.fpu_ld !== 1'b0) begin
      errors++; $display("FAIL add_retire: ret/en/ld=%b%b%b expected 100",
                         bus.retired, bus.fpu_enable, bus.fpu_ld); end
    checks++; if ({bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3} !== {5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL add_addr_retire: %0d/%0d/%0d expected 1/2/3",
                         bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3); end
    step();                                    // cycle 7: IDLE, addresses hold
    checks++; if (bus.retired !== 1'b0 || bus.busy !== 1'b0 || bus.fpu_addr3 !== 5'd3) begin
      errors++; $display("FAIL add_idle: ret/busy=%b%b addr3=%0d expected 00/3",
                         bus.retired, bus.busy, bus.fpu_addr3); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got[$];
    bit         rdy[5];
    set_cmd(OP_MUL, 5'd7, 5'd8, 5'd10);
    bus.cmd_valid = 1'b1;
    step(); bus.cmd_valid = 1'b0;
    step(); step();                            // head command now stalled in EXEC
    for (int i = 0; i < 5; i++) begin
      set_cmd(OP_ADD, 5'(i), 5'(i + 1), 5'(11 + i));
      bus.cmd_valid = 1'b1;
      rdy[i] = bus.cmd_ready;
      step();
    end
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rdy[i] !== (i < 4)) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, rdy[i], i < 4); end
    end
    for (int i = 0; i < 120; i++) begin
      if (bus.retired) got.push_back(bus.fpu_addr3);
      bus.fpu_done  = bus.fpu_enable && !bus.fpu_ld;
      bus.fpu_flags = 5'b0;
      step();
    end
    bus.fpu_done = 1'b0;
    checks++; if (got.size() != 5) begin
      errors++; $display("FAIL b2b_count: got %0d retires expected 5", got.size()); end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      checks++; if (got[k] !== 5'(10 + k)) begin
        errors++; $display("FAIL b2b_order[%0d]: dst %0d expected %0d", k, got[k], 10 + k); end
    end
  endtask

  task automatic test_flags();
    int ld, ex; bit ret;
    logic [4:0] f_dz, f_nx, f_inv;
    f_dz = '0; f_dz[FLAG_DZ] = 1'b1;
    f_nx = '0; f_nx[FLAG_NX] = 1'b1;
    f_inv = '0; f_inv[FLAG_INV] = 1'b1;
    bus.flags_clr = 1'b1; step(); bus.flags_clr = 1'b0;
    checks++; if (bus.sticky_flags !== 5'b0) begin
      errors++; $display("FAIL flags_clr_idle: got %b expected 00000", bus.sticky_flags); end
    run_cmd(OP_DIV, 5'd1, 5'd2, 5'd3, 2, f_dz, 1'b0, ld, ex, ret);
    checks++; if (!ret || bus.sticky_flags !== 5'b01000) begin
      errors++; $display("FAIL flags_div: ret=%b sticky=%b expected 1/01000", ret, bus.sticky_flags);
    end
    run_cmd(OP_SQRT, 5'd4, 5'd0, 5'd5, 0, f_nx, 1'b0, ld, ex, ret);
    checks++; if (!ret || bus.sticky_flags !== 5'b01001) begin
      errors++; $display("FAIL flags_sqrt: ret=%b sticky=%b expected 1/01001", ret, bus.sticky_flags);
    end
    run_cmd(OP_ADD, 5'd6, 5'd7, 5'd8, 1, f_inv, 1'b1, ld, ex, ret);
    checks++; if (!ret || bus.sticky_flags !== 5'b10000) begin
      errors++; $display("FAIL flags_clr_merge: ret=%b sticky=%b expected 1/10000",
                         ret, bus.sticky_flags); end
  endtask

  task automatic test_timeout();
    int ld, ex; bit ret;
    run_cmd(OP_MUL, 5'd9, 5'd9, 5'd9, -1, 5'b11111, 1'b0, ld, ex, ret);
    checks++; if (!ret || ex != TIMEOUT || ld != 1) begin
      errors++; $display("FAIL timeout_len: ret=%b exec=%0d ld=%0d expected 1/%0d/1",
                         ret, ex, ld, TIMEOUT); end
    checks++; if (bus.timeout_err !== 1'b1 || bus.sticky_flags !== 5'b10000) begin
      errors++; $display("FAIL timeout_status: to=%b sticky=%b expected 1/10000",
                         bus.timeout_err, bus.sticky_flags); end
    run_cmd(OP_CMP, 5'd1, 5'd1, 5'd2, 1, 5'b00010, 1'b0, ld, ex, ret);
    checks++; if (!ret || ex != 2 || bus.sticky_flags !== 5'b10010) begin
      errors++; $display("FAIL timeout_next: ret=%b exec=%0d sticky=%b expected 1/2/10010",
                         ret, ex, bus.sticky_flags); end
  endtask

  task automatic test_illegal();
    set_cmd(3'd6, 5'd1, 5'd1, 5'd1);
    bus.cmd_valid = 1'b1;
    step();                                    // illegal entry at head
    set_cmd(OP_MUL, 5'd12, 5'd13, 5'd14);
    checks++; if (bus.retired !== 1'b1 || bus.fpu_ld !== 1'b0 || bus.illegal_op !== 1'b0) begin
      errors++; $display("FAIL ill_drop: ret/ld/ill=%b%b%b expected 100",
                         bus.retired, bus.fpu_ld, bus.illegal_op); end
    step(); bus.cmd_valid = 1'b0;              // mul popped
    checks++; if (bus.illegal_op !== 1'b1 || bus.retired !== 1'b0 || bus.fpu_ld !== 1'b0) begin
      errors++; $display("FAIL ill_flag: ill/ret/ld=%b%b%b expected 100",
                         bus.illegal_op, bus.retired, bus.fpu_ld); end
    step();
    checks++; if (bus.fpu_ld !== 1'b1 || {bus.fpu_opcode, bus.fpu_addr1, bus.fpu_addr2,
                  bus.fpu_addr3} !== {OP_MUL, 5'd12, 5'd13, 5'd14}) begin
      errors++; $display("FAIL ill_mul_load: ld=%b op=%0d dst=%0d expected 1/1/14",
                         bus.fpu_ld, bus.fpu_opcode, bus.fpu_addr3); end
    step();
    bus.fpu_done = 1'b1; bus.fpu_flags = 5'b0;
    step(); bus.fpu_done = 1'b0;
    checks++; if (bus.retired !== 1'b1) begin
      errors++; $display("FAIL ill_mul_retire: got %b expected 1", bus.retired); end
    bus.flags_clr = 1'b1; step(); bus.flags_clr = 1'b0;
    checks++; if (bus.illegal_op !== 1'b1 || bus.timeout_err !== 1'b1 || bus.sticky_flags !== 5'b0)
    begin errors++; $display("FAIL clr_scope: ill/to=%b%b sticky=%b expected 11/00000",
                             bus.illegal_op, bus.timeout_err, bus.sticky_flags); end
  endtask

  task automatic test_random();
    fpu_cmd_t   exp_q[$];
    fpu_cmd_t   c;
    int         pending = 0, exec_cnt = 0, delay = 0, exp_ex;
    bit         loaded = 1'b0, exec, done, clr, ill_seen;
    logic [4:0] sticky_m = '0, fl;
    bit         to_m = 1'b0, ill_m = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int cyc = 0; cyc < 3300; cyc++) begin
      checks++; if (bus.sticky_flags !== sticky_m || bus.timeout_err !== to_m ||
                    bus.illegal_op !== ill_m) begin
        errors++; $display("FAIL rnd_status@%0d: sticky=%b to=%b ill=%b expected %b/%b/%b", cyc,
                           bus.sticky_flags, bus.timeout_err, bus.illegal_op, sticky_m, to_m, ill_m);
      end
      checks++; if (bus.busy !== (pending > 0)) begin
        errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, bus.busy, pending > 0); end
      if (pending < DEPTH || pending > DEPTH) begin
        checks++; if (bus.cmd_ready !== (pending < DEPTH)) begin
          errors++; $display("FAIL rnd_ready@%0d: got %b expected %b (pending %0d)",
                             cyc, bus.cmd_ready, pending < DEPTH, pending); end
      end
      if (bus.fpu_ld) begin
        checks++;
        if (exp_q.size() == 0 || loaded || exp_q[0].opcode > OP_CMP ||
            {bus.fpu_opcode, bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3} !== exp_q[0]) begin
          errors++; $display("FAIL rnd_load@%0d: got %h expected %h", cyc,
            {bus.fpu_opcode, bus.fpu_addr1, bus.fpu_addr2, bus.fpu_addr3},
            exp_q.size() ? exp_q[0] : '0);
        end
        loaded = 1'b1; exec_cnt = 0; delay = $urandom_range(0, 17);
      end
      ill_seen = 1'b0;
      if (bus.retired) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_retire@%0d: retired with nothing pending", cyc);
        end else if (loaded) begin
          exp_ex = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
          if (exec_cnt != exp_ex || bus.fpu_enable !== 1'b0) begin
            errors++; $display("FAIL rnd_exec_len@%0d: exec=%0d en=%b expected %0d/0",
                               cyc, exec_cnt, bus.fpu_enable, exp_ex); end
          void'(exp_q.pop_front()); pending--; loaded = 1'b0;
        end else begin
          if (exp_q[0].opcode <= OP_CMP) begin
            errors++; $display("FAIL rnd_drop@%0d: dropped op %0d expected illegal op",
                               cyc, exp_q[0].opcode); end
          void'(exp_q.pop_front()); pending--; ill_seen = 1'b1;
        end
      end
      exec = loaded && bus.fpu_enable && !bus.fpu_ld;
      fl   = 5'($urandom);
      clr  = ($urandom_range(0, 9) == 0);
      if (exec) begin
        done = (exec_cnt == delay);
        exec_cnt++;
      end else done = ($urandom_range(0, 5) == 0);
      bus.fpu_done = done; bus.fpu_flags = fl; bus.flags_clr = clr;
      sticky_m = (clr ? 5'b0 : sticky_m) | ((exec && done) ? fl : 5'b0);
      if (exec && !done && exec_cnt == TIMEOUT) to_m = 1'b1;
      if (ill_seen) ill_m = 1'b1;
      bus.cmd_valid = (cyc < 3000) && ($urandom_range(0, 2) != 0);
      c.opcode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      c.src1 = 5'($urandom); c.src2 = 5'($urandom); c.dst = 5'($urandom);
      set_cmd(c.opcode, c.src1, c.src2, c.dst);
      if (bus.cmd_valid && bus.cmd_ready) begin exp_q.push_back(c); pending++; end
      step();
    end
    idle_inputs();
    checks++; if (exp_q.size() != 0 || pending != 0) begin
      errors++; $display("FAIL rnd_drain: %0d commands never retired expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0, en_seen = 1'b0, ret_seen = 1'b0, ld_seen = 1'b0;
    set_cmd(OP_ADD, 5'd4, 5'd5, 5'd6);
    bus.cmd_valid = 1'b1; step(); bus.cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (bus.fpu_enable && !bus.fpu_ld) reached = 1'b1; else step();
    end
    checks++; if (!reached) begin
      errors++; $display("FAIL rstmid_exec: EXEC not reached got 0 expected 1"); end
    bus.cmd_valid = 1'b1; step(); set_cmd(OP_MUL, 5'd1, 5'd2, 5'd3); step();
    bus.cmd_valid = 1'b0;
    rst = 1'b1; #1;
    checks++; if (bus.fpu_enable !== 1'b0 || bus.fpu_ld !== 1'b0 || bus.busy !== 1'b0 ||
                  bus.cmd_ready !== 1'b1 || bus.retired !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: en/ld/busy/rdy/ret=%b%b%b%b%b expected 00010",
        bus.fpu_enable, bus.fpu_ld, bus.busy, bus.cmd_ready, bus.retired); end
    checks++; if (bus.sticky_flags !== 5'b0 || bus.timeout_err !== 1'b0 || bus.illegal_op !== 1'b0)
    begin errors++; $display("FAIL rstmid_status: sticky=%b to=%b ill=%b expected 0",
                             bus.sticky_flags, bus.timeout_err, bus.illegal_op); end
    step(); step(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.fpu_enable) en_seen = 1'b1;
      if (bus.retired || bus.busy) ret_seen = 1'b1;
      step();
    end
    checks++; if (en_seen || ret_seen) begin
      errors++; $display("FAIL rstmid_quiet: enable=%b retired_or_busy=%b expected 0/0",
                         en_seen, ret_seen); end
    set_cmd(OP_DIV, 5'd20, 5'd21, 5'd22);
    bus.cmd_valid = 1'b1; step(); bus.cmd_valid = 1'b0;
    for (int i = 0; i < 6 && !ld_seen; i++) begin
      if (bus.fpu_ld && bus.fpu_addr3 == 5'd22) ld_seen = 1'b1; else step();
    end
    checks++; if (!ld_seen) begin
      errors++; $display("FAIL rstmid_resume: LOAD of new command got 0 expected 1"); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_flags();
    test_timeout();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_sched.md
FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 DEPTH, 4, command FIFO depth; power of two, 2..16.
REQ-002 TIMEOUT, 15, maximum EXEC cycles to wait for fpu_done before aborting.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_opcode  in  3  0 add, 1 mul, 2 div, 3 sqrt, 4 compare.
REQ-009 cmd_src1, cmd_src2, cmd_dst  in  5 each  operand and result register-file addresses.
REQ-010 fpu_opcode  out  3  opcode driven to the FPU.
REQ-011 fpu_addr1, fpu_addr2, fpu_addr3  out  5 each  addresses driven to the FPU.
REQ-012 fpu_ld  out  1  operand-load strobe.
REQ-013 fpu_enable  out  1  FPU operate enable.
REQ-014 fpu_done  in  1  FPU completion pulse.
REQ-015 fpu_flags  in  5  {inv, div_zero, ov, un, inexact}, valid while fpu_done is high.
REQ-016 flags_clr  in  1  clears sticky_flags.
REQ-017 sticky_flags  out  5  accumulated exception flags, same bit order as fpu_flags.
REQ-018 busy  out  1  high when state != IDLE or FIFO is non-empty.
REQ-019 retired  out  1  one-cycle pulse per completed or aborted command.
REQ-020 timeout_err, illegal_op  out  1 each  sticky error flags.

Function
REQ-021 Command FIFO: cmd_ready = !full. A push while full is ignored. Simultaneous push and pop leaves the count unchanged. Read/write pointers wrap modulo DEPTH.
REQ-022 FSM states: IDLE, LOAD, EXEC, RETIRE.
REQ-023 IDLE with the FIFO non-empty: pop the head into the current-command registers in that cycle and go to LOAD next cycle. An entry with opcode > 4 is popped, sets illegal_op and pulses retired, and the FSM stays in IDLE.
REQ-024 LOAD lasts exactly 1 cycle: fpu_ld=1, fpu_enable=1. Go to EXEC and clear the wait counter.
REQ-025 EXEC: fpu_ld=0, fpu_enable=1, wait counter increments each cycle.
  - fpu_done=1: merge fpu_flags into sticky_flags, go to RETIRE.
  - Counter reaches TIMEOUT first: set timeout_err, no flag merge, go to RETIRE.
REQ-026 RETIRE lasts exactly 1 cycle: fpu_enable=0, fpu_ld=0, retired=1, then go to IDLE. This guarantees at least 1 enable-low cycle between commands.
REQ-027 fpu_opcode and fpu_addr1/2/3 are driven from the current-command registers. They are stable from LOAD through RETIRE and hold their last value in IDLE.
REQ-028 Same cycle as a flag merge, flags_clr clears first, then the merge sets the new bits, so new flags are not lost. flags_clr does not clear timeout_err or illegal_op.
REQ-029 Latency: a command pushed into an empty FIFO at cycle t gives pop at t+1, LOAD at t+2, EXEC from t+3, and retired 1 cycle after fpu_done.
REQ-030 fpu_done while not in EXEC is ignored.

Reset
REQ-031 While rst is high, asynchronously:
  - state=IDLE, FIFO empty with pointers 0, current-command registers 0.
  - sticky_flags=0, timeout_err=0, illegal_op=0.
  - fpu_ld=0, fpu_enable=0, retired=0, busy=0, cmd_ready=1.
REQ-032 Reset mid-operation abandons the in-flight command and all queued commands. No retired pulse is issued for them.

Structure
REQ-033 Shared package fpu_pkg holds:
  - opcode constants (OP_ADD..OP_CMP),
  - FSM state enum,
  - flag bit indices,
  - command struct {opcode, src1, src2, dst}.
REQ-034 One sub-module, fpu_cmd_fifo, parameterised by DEPTH and the command width. The FSM, counters and flag logic stay in fpu_sched.

Verification
REQ-035 Single add {op 0, src 1, 2, dst 3} pushed at cycle 0, fpu_done at cycle 5:
  - LOAD at cycle 2, with fpu_ld=1 and fpu_enable=1 for 1 cycle.
  - retired at cycle 6.
  - addr outputs read 1/2/3 throughout.
REQ-036 Push 5 commands back-to-back with DEPTH=4 while the FSM is stalled in EXEC: the 5th sees cmd_ready=0 and is not accepted. Retire order matches push order.
REQ-037 Div with fpu_flags=5'b01000 at done, then sqrt with 5'b00001: sticky_flags=5'b01001. Assert flags_clr in the merge cycle of a third op carrying 5'b10000: result is 5'b10000.
REQ-038 fpu_done never asserted: EXEC lasts exactly 15 cycles, then timeout_err=1, retired pulses, sticky_flags unchanged, and the next command proceeds normally.
REQ-039 Push opcode 6 followed by a mul: illegal_op=1, retired pulses with no LOAD, and the mul then executes normally.
REQ-040 Assert rst during EXEC with 2 commands queued: all outputs go to reset values immediately, busy=0, and no further fpu_enable until a new push.
